// File: rtl/sift_out_adder_ctrl.sv
// -----------------------------------------------------------------------------
// sift_out_adder_ctrl
//
// Shares one sift_out_adder between two requesters. A round-robin arbiter
// picks a requester in IDLE, the operands are registered onto the adder and
// held for the settle latency, the adder result is captured, and it is
// returned to the winner over a valid/ready response channel. The block also
// sequences the adder's K control: K=1 for the first operation after reset or
// re-init, K=0 afterwards.
//
// Parameters
//   WIDTH  operand/sum width (must match the adder's adder_width)
//   LAT    cycles from stable operands to valid sum/cout, 1..15
//   CNT_W  width of the completed-operation counter
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req{0,1}_valid/ready     request handshake per requester
//   req{0,1}_a/_b/_cin       request operands per requester
//   rsp{0,1}_valid/ready     response handshake per requester
//   rsp_sum, rsp_cout        captured result, shared by both responses
//   reinit                   pulse: next operation runs with K=1
//   add_in1/in2/cin, add_K   drive the shared adder
//   add_sum, add_cout        adder result
//   busy                     high whenever not IDLE
//   op_count                 completed operations, saturating
// -----------------------------------------------------------------------------
module sift_out_adder_ctrl #(
    parameter int WIDTH = 32,
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    input  logic             reinit,
    output logic [WIDTH-1:0] add_in1,
    output logic [WIDTH-1:0] add_in2,
    output logic             add_cin,
    output logic             add_K,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0]       LAT_C   = 4'(LAT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0] state;
    logic       rr_favor1;    // 1: req1 wins a tie
    logic       grant_id;     // requester owning the in-flight operation
    logic [3:0] settle_cnt;
    logic       init_done;    // first K=1 operation has completed
    logic       reinit_pend;  // reinit seen while an operation was in flight
    logic       pick1;
    logic       accept;
    logic       rsp_hs;

    // A lone valid requester wins; on a tie the rr pointer decides.
    assign pick1 = req1_valid && (!req0_valid || rr_favor1);

    // Ready is gated by rst so that it is also 0 while reset is held.
    assign req0_ready = !rst && (state == S_IDLE) && req0_valid && !pick1;
    assign req1_ready = !rst && (state == S_IDLE) && pick1;
    assign accept     = req0_ready || req1_ready;

    assign rsp0_valid = (state == S_RESP) && !grant_id;
    assign rsp1_valid = (state == S_RESP) &&  grant_id;
    assign rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign busy  = (state != S_IDLE);
    assign add_K = ~init_done;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order in the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register, including the datapath operand and result
            // holding registers, is reset so outputs are defined immediately.
            state       <= S_IDLE;
            rr_favor1   <= 1'b0;
            grant_id    <= 1'b0;
            settle_cnt  <= '0;
            init_done   <= 1'b0;
            reinit_pend <= 1'b0;
            add_in1     <= '0;
            add_in2     <= '0;
            add_cin     <= 1'b0;
            rsp_sum     <= '0;
            rsp_cout    <= 1'b0;
            op_count    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (reinit) begin
                        init_done <= 1'b0;
                    end
                    if (accept) begin
                        add_in1    <= pick1 ? req1_a   : req0_a;
                        add_in2    <= pick1 ? req1_b   : req0_b;
                        add_cin    <= pick1 ? req1_cin : req0_cin;
                        grant_id   <= pick1;
                        rr_favor1  <= !pick1;
                        settle_cnt <= '0;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (reinit) begin
                        reinit_pend <= 1'b1;
                    end
                    settle_cnt <= settle_cnt + 4'd1;
                    // Counter starts at 0 on entry, so EXEC lasts LAT+1 cycles.
                    if (settle_cnt == LAT_C) begin
                        rsp_sum  <= add_sum;
                        rsp_cout <= add_cout;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (reinit) begin
                        reinit_pend <= 1'b1;
                    end
                    if (rsp_hs) begin
                        // A pending (or same-cycle) reinit overrides the set so
                        // the following operation runs with K=1 again.
                        init_done   <= !(reinit_pend || reinit);
                        reinit_pend <= 1'b0;
                        if (op_count != CNT_MAX) begin
                            op_count <= op_count + 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sift_out_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sift_out_adder_ctrl
//
// Scoreboarded bench for sift_out_adder_ctrl. Stimulus pushes the expected
// response (requester id, sum, cout, K used) when a request is granted; a
// monitor pops and compares at every response handshake. A second instance
// built with LAT=4 checks the longer settle timing directly.
// -----------------------------------------------------------------------------
module tb_sift_out_adder_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             k;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT, LAT=1 ----------------
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             req0_cin = 1'b0, req1_cin = 1'b0;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             reinit = 1'b0;
    logic [WIDTH-1:0] add_in1, add_in2, add_sum;
    logic             add_cin, add_K, add_cout;
    logic             busy;
    logic [CNT_W-1:0] op_count;
    logic [WIDTH:0]   add_full;

    // Behavioural adder: plain a+b+cin.
    assign add_full = (WIDTH+1)'(add_in1) + (WIDTH+1)'(add_in2) + (WIDTH+1)'(add_cin);
    assign add_sum  = add_full[WIDTH-1:0];
    assign add_cout = add_full[WIDTH];

    sift_out_adder_ctrl #(.WIDTH(WIDTH), .LAT(1), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .reinit(reinit),
        .add_in1(add_in1), .add_in2(add_in2), .add_cin(add_cin), .add_K(add_K),
        .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy), .op_count(op_count)
    );

    // ---------------- second DUT, LAT=4 ----------------
    logic             l4_req0_valid = 1'b0;
    logic             l4_req0_ready, l4_req1_ready;
    logic [WIDTH-1:0] l4_req0_a = '0, l4_req0_b = '0;
    logic             l4_req0_cin = 1'b0;
    logic             l4_rsp0_valid, l4_rsp1_valid;
    logic [WIDTH-1:0] l4_rsp_sum;
    logic             l4_rsp_cout;
    logic [WIDTH-1:0] l4_in1, l4_in2, l4_sum;
    logic             l4_cin, l4_K, l4_cout, l4_busy;
    logic [CNT_W-1:0] l4_op_count;
    logic [WIDTH:0]   l4_full;

    assign l4_full = (WIDTH+1)'(l4_in1) + (WIDTH+1)'(l4_in2) + (WIDTH+1)'(l4_cin);
    assign l4_sum  = l4_full[WIDTH-1:0];
    assign l4_cout = l4_full[WIDTH];

    sift_out_adder_ctrl #(.WIDTH(WIDTH), .LAT(4), .CNT_W(CNT_W)) u_dut_lat4 (
        .clk(clk), .rst(rst),
        .req0_valid(l4_req0_valid), .req0_ready(l4_req0_ready),
        .req0_a(l4_req0_a), .req0_b(l4_req0_b), .req0_cin(l4_req0_cin),
        .req1_valid(1'b0), .req1_ready(l4_req1_ready),
        .req1_a('0), .req1_b('0), .req1_cin(1'b0),
        .rsp0_valid(l4_rsp0_valid), .rsp0_ready(1'b1),
        .rsp1_valid(l4_rsp1_valid), .rsp1_ready(1'b1),
        .rsp_sum(l4_rsp_sum), .rsp_cout(l4_rsp_cout), .reinit(1'b0),
        .add_in1(l4_in1), .add_in2(l4_in2), .add_cin(l4_cin), .add_K(l4_K),
        .add_sum(l4_sum), .add_cout(l4_cout),
        .busy(l4_busy), .op_count(l4_op_count)
    );

    // ---------------- scoreboard and checking ----------------
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: K observed during EXEC, and response compare at handshake.
    logic in_exec = 1'b0;
    logic k_seen  = 1'b0;
    logic k_moved = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            in_exec = 1'b0;
            k_moved = 1'b0;
            check("rst_no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        end else begin
            if (busy && !rsp0_valid && !rsp1_valid) begin
                if (!in_exec) begin
                    k_seen  = add_K;
                    k_moved = 1'b0;
                end else if (add_K !== k_seen) begin
                    k_moved = 1'b1;
                end
                in_exec = 1'b1;
            end else begin
                in_exec = 1'b0;
            end
            if (busy && (req0_ready || req1_ready)) begin
                check("grant_while_busy", {req0_ready, req1_ready}, 2'b00);
            end
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_id",      rsp1_valid, e.id);
                    check("rsp_both",    rsp0_valid && rsp1_valid, 1'b0);
                    check("rsp_sum",     rsp_sum, e.sum);
                    check("rsp_cout",    rsp_cout, e.cout);
                    check("exec_k",      k_seen, e.k);
                    check("exec_k_flat", k_moved, 1'b0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Caller has already driven reqN_valid/operands. Waits for the grant,
    // pushes the expected response, returns #1 after the accepting edge.
    task automatic grant(input logic id, input logic [WIDTH-1:0] es,
                         input logic ec, input logic ek);
        int n = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("grant_ready", id ? req1_ready : req0_ready, 1'b1);
        check("grant_other", id ? req0_ready : req1_ready, 1'b0);
        sb.push_back('{id: id, sum: es, cout: ec, k: ek});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic op0(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic [WIDTH-1:0] es,
                       input logic ec, input logic ek);
        req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
        grant(1'b0, es, ec, ek);
        req0_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Reset values, with a request already pending during reset.
        req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",     busy, 1'b0);
        check("rst_k",        add_K, 1'b1);
        check("rst_count",    op_count, 0);
        check("rst_ready",    {req0_ready, req1_ready}, 2'b00);
        check("rst_in1",      add_in1, 0);
        check("rst_sum",      rsp_sum, 0);
        rst = 1'b0;
        req0_valid = 1'b0;
        @(posedge clk);
        #1;

        // First op: 5+3, LAT=1, response held off so timing is observable.
        rsp0_ready = 1'b0;
        op0(32'h5, 32'h3, 1'b0, 32'h8, 1'b0, 1'b1);
        @(negedge clk);   // t+1
        check("t1_k", add_K, 1'b1);
        check("t1_busy", busy, 1'b1);
        check("t1_rsp", rsp0_valid, 1'b0);
        check("t1_in1", add_in1, 32'h5);
        @(negedge clk);   // t+2
        check("t2_k", add_K, 1'b1);
        check("t2_rsp", rsp0_valid, 1'b0);
        @(negedge clk);   // t+3
        check("t3_rsp", rsp0_valid, 1'b1);
        @(posedge clk);
        #1 rsp0_ready = 1'b1;
        @(posedge clk);   // handshake edge
        #1;
        check("first_k_after", add_K, 1'b0);
        check("first_count", op_count, 1);
        check("first_busy", busy, 1'b0);

        // Round robin from reset: both requesters valid every cycle.
        do_reset();
        req0_a = 32'h1;  req0_b = 32'h2;  req0_cin = 1'b0;
        req1_a = 32'h10; req1_b = 32'h20; req1_cin = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        grant(1'b0, 32'h3,  1'b0, 1'b1);
        grant(1'b1, 32'h31, 1'b0, 1'b0);
        grant(1'b0, 32'h3,  1'b0, 1'b0);
        grant(1'b1, 32'h31, 1'b0, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        check("rr_count", op_count, 4);

        // Back-pressured response: result must hold for 5 cycles.
        rsp1_ready = 1'b0;
        req1_a = 32'hFFFF_FFFF; req1_b = 32'h1; req1_cin = 1'b0; req1_valid = 1'b1;
        grant(1'b1, 32'h0, 1'b1, 1'b0);
        req1_valid = 1'b0;
        req0_a = 32'h7; req0_b = 32'h8; req0_cin = 1'b0; req0_valid = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!rsp1_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("hold_valid", rsp1_valid, 1'b1);
            check("hold_sum",   rsp_sum, 32'h0);
            check("hold_cout",  rsp_cout, 1'b1);
            check("hold_busy",  busy, 1'b1);
            check("hold_req0",  req0_ready, 1'b0);
            check("hold_rsp0",  rsp0_valid, 1'b0);
        end
        @(posedge clk);
        #1 rsp1_ready = 1'b1;
        grant(1'b0, 32'hF, 1'b0, 1'b0);
        req0_valid = 1'b0;
        wait_idle();

        // reinit during the 3rd op after reset.
        do_reset();
        op0(32'hA,        32'hB,        1'b0, 32'h15,       1'b0, 1'b1);
        wait_idle();
        op0(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h1,      1'b1, 1'b0);
        wait_idle();
        op0(32'h0,        32'h0,        1'b1, 32'h1,        1'b0, 1'b0);
        reinit = 1'b1;
        @(posedge clk);
        #1 reinit = 1'b0;
        wait_idle();
        check("reinit_k_idle", add_K, 1'b1);
        op0(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b1);
        wait_idle();
        op0(32'hFFFF_FFFE, 32'h1, 1'b1, 32'h0, 1'b1, 1'b0);
        wait_idle();
        check("reinit_count", op_count, 5);

        // Reset in EXEC aborts the op immediately.
        op0(32'h100, 32'h200, 1'b0, 32'h300, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("abort_busy",  busy, 1'b0);
        check("abort_k",     add_K, 1'b1);
        check("abort_count", op_count, 0);
        check("abort_in",    {add_in1, add_in2}, 0);
        check("abort_rsp",   {rsp0_valid, rsp1_valid}, 2'b00);
        void'(sb.pop_back());
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        op0(32'h2, 32'h2, 1'b1, 32'h5, 1'b0, 1'b1);
        wait_idle();
        check("post_abort_count", op_count, 1);

        // LAT=4 instance: operands stable for 5 cycles, response at t+6.
        l4_req0_a = 32'h1234; l4_req0_b = 32'h10; l4_req0_cin = 1'b1;
        l4_req0_valid = 1'b1;
        @(negedge clk);
        check("l4_ready", l4_req0_ready, 1'b1);
        @(posedge clk);
        #1 l4_req0_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("l4_ops", {l4_in1, l4_in2, 31'b0, l4_cin}, {32'h1234, 32'h10, 32'h1});
            check("l4_exec", {l4_busy, l4_rsp0_valid, l4_K}, 3'b101);
        end
        @(negedge clk);
        check("l4_rsp_valid", l4_rsp0_valid, 1'b1);
        check("l4_rsp_sum",   l4_rsp_sum, 32'h1245);
        check("l4_rsp_cout",  l4_rsp_cout, 1'b0);
        @(posedge clk);
        #1;
        check("l4_count", l4_op_count, 1);

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sift_out_adder_ctrl.md
Name: sift_out_adder_ctrl

Overview:
Scheduler that shares one sift_out_adder instance between two requesters. It arbitrates requests round-robin, drives the adder operands, and holds them stable for the adder settle latency. It sequences the adder's K control: K=1 for the first operation after reset or re-init, K=0 afterwards. It captures sum/cout and returns them to the winning requester over a valid/ready response handshake.

Parameters:
WIDTH, 32, operand/sum width; must match the adder's adder_width.
LAT, 1, clock cycles from operands stable at the adder to sum/cout valid; legal range 1..15.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_a, req0_b  input  WIDTH each  requester 0 operands.
req0_cin  input  1  requester 0 carry-in.
req1_valid, req1_ready, req1_a, req1_b, req1_cin  as above, for requester 1.
rsp0_valid  output  1  result for requester 0 is available.
rsp0_ready  input  1  requester 0 takes the result.
rsp1_valid  output  1  result for requester 1 is available.
rsp1_ready  input  1  requester 1 takes the result.
rsp_sum  output  WIDTH  captured sum; shared by both response channels.
rsp_cout  output  1  captured carry-out.
reinit  input  1  single-cycle pulse; forces K=1 on the next operation.
add_in1, add_in2  output  WIDTH each  adder operands.
add_cin  output  1  adder carry-in.
add_K  output  1  adder K control.
add_sum  input  WIDTH  adder sum.
add_cout  input  1  adder carry-out.
busy  output  1  high in any state other than IDLE.
op_count  output  CNT_W  number of completed operations; saturates at all-ones.

Behaviour:
- Reset values (asynchronous): state=IDLE; all ready/valid outputs=0; rsp_sum=0, rsp_cout=0; add_in1=0, add_in2=0, add_cin=0; init_done=0, so add_K=1; rr pointer favours req0; op_count=0; busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - reqN_ready is combinational and high only in IDLE, only for the requester the arbiter picks.
  - If only one requester is valid, it wins.
  - If both are valid, the requester the rr pointer favours wins.
  - On accept (valid & ready): latch a/b/cin into add_in1/add_in2/add_cin, record the grant id, flip the rr pointer to favour the other requester, clear the settle counter, go to EXEC.
- EXEC:
  - Operands are held constant.
  - The settle counter increments each cycle.
  - In the cycle where counter==LAT, add_sum/add_cout are registered into rsp_sum/rsp_cout, and the FSM goes to RESP.
  - EXEC lasts LAT+1 cycles.
- RESP:
  - rsp<grant>_valid=1; the other rsp valid stays 0.
  - rsp_sum/rsp_cout are held stable until rsp<grant>_ready=1.
  - On handshake: valid drops next cycle, op_count increments (saturating), init_done<=1, FSM returns to IDLE.
  - add_in* keep their last value.
- Latency: accept at cycle t -> rsp valid at cycle t+LAT+2 (t+3 for LAT=1); earliest next accept is the cycle after the response handshake.
- add_K = ~init_done in every state:
  - Stays 1 through the whole first operation's EXEC.
  - Falls to 0 only after the first response handshake.
- reinit:
  - Clears init_done when it arrives in IDLE.
  - If it arrives in EXEC/RESP, it is registered as pending and clears init_done at the handshake, overriding the set, so the next op runs with K=1.
  - The in-flight op's K is unchanged.
- Sum/carry arithmetic is entirely the adder's; this block performs no arithmetic and truncates nothing.
- A requester dropping valid before ready: no accept and no state change.
- reqN_valid asserted while its own response is pending is simply not granted until IDLE.
- Reset asserted mid-EXEC/RESP:
  - The op is aborted, and no response is issued.
  - All outputs return to their reset values immediately.
  - K returns to 1.

Test Plan:
- Reset, then req0 {a=0x0000_0005, b=0x0000_0003, cin=0}, LAT=1, adder model echoing a+b -> req0_ready at t; add_K=1 from t+1 to t+2; rsp0_valid at t+3 with sum=0x8, cout=0; add_K=0 after handshake; op_count=1.
- req0 and req1 both valid every cycle, responses taken immediately -> grants alternate 0,1,0,1 starting with req0; never two grants without a response handshake in between.
- req1 {a=0xFFFF_FFFF, b=0x0000_0001, cin=0}, rsp1_ready held low 5 cycles -> rsp1_valid and sum=0x0, cout=1 held steady for all 5 cycles; busy=1 throughout; req0_ready stays 0 while req0 is valid.
- reinit pulsed during EXEC of the 3rd op -> that op completes with add_K=0; 4th op has add_K=1; 5th op has add_K=0.
- rst asserted in EXEC of an op -> all outputs at reset values in the same cycle; no rsp valid ever appears for the aborted op; next op runs with add_K=1 and op_count restarts from 0.
- LAT=4 build, single request -> operands stable for 5 cycles; response at t+6.
